// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encodings,
// FSM states and default latencies.
package md_pkg;

   localparam int MD_OP_W            = 3;
   localparam int MD_MULT_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF  = 10;

   typedef enum logic [MD_OP_W-1:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } md_state_e;

endpackage

// File: rtl/md_calc.sv
// Combinational datapath: signed/unsigned 32x32 multiply and divide,
// packed as {hi, lo}; flags a zero divisor.
module md_calc
   import md_pkg::*;
(
   input  logic [MD_OP_W-1:0] op_i,
   input  logic [31:0]        a_i,
   input  logic [31:0]        b_i,
   output logic [63:0]        res_o,
   output logic               div_zero_o
);

   logic signed [63:0] a_sx, b_sx, prod_s;
   logic        [63:0] prod_u;
   logic               b_zero, s_ovf;
   logic signed [31:0] a_s, bdiv_s, quot_s, rem_s;
   logic        [31:0] bdiv_u, quot_u, rem_u;

   assign a_sx   = {{32{a_i[31]}}, a_i};
   assign b_sx   = {{32{b_i[31]}}, b_i};
   assign prod_s = a_sx * b_sx;
   assign prod_u = {32'd0, a_i} * {32'd0, b_i};

   assign b_zero = (b_i == 32'd0);
   // -2^31 / -1 overflows; dividing by 1 yields the wrapped quotient and zero remainder.
   assign s_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

   assign a_s    = a_i;
   assign bdiv_s = (b_zero || s_ovf) ? 32'sd1 : b_i;
   assign quot_s = a_s / bdiv_s;
   assign rem_s  = a_s % bdiv_s;

   assign bdiv_u = b_zero ? 32'd1 : b_i;
   assign quot_u = a_i / bdiv_u;
   assign rem_u  = a_i % bdiv_u;

   assign div_zero_o = b_zero;

   always_comb begin
      res_o = 64'd0;
      case (op_i)
         MD_MULT:  res_o = prod_s;
         MD_MULTU: res_o = prod_u;
         MD_DIV:   res_o = {rem_s, quot_s};
         MD_DIVU:  res_o = {rem_u, quot_u};
         default:  res_o = 64'd0;
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO: fixed-latency mult/div with results held
// in pending registers until the completion edge, plus mthi/mtlo.
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic [MD_OP_W-1:0] MDOp,
   input  logic [31:0]        A,
   input  logic [31:0]        B,
   output logic               Busy,
   output logic [31:0]        HI,
   output logic [31:0]        LO
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   md_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [63:0]       pend_q, pend_d;
   logic              pend_ok_q, pend_ok_d;
   logic [31:0]       hi_q, hi_d, lo_q, lo_d;
   logic [63:0]       calc_res;
   logic              calc_div_zero;
   logic              last_cycle, accept;

   md_calc u_calc (
      .op_i       (MDOp),
      .a_i        (A),
      .b_i        (B),
      .res_o      (calc_res),
      .div_zero_o (calc_div_zero)
   );

   // A start is taken when idle or on the completion edge (back-to-back issue).
   assign last_cycle = (state_q == S_RUN) && (cnt_q == CNT_W'(1));
   assign accept     = Start && ((state_q == S_IDLE) || last_cycle);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      pend_ok_d = pend_ok_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      if (state_q == S_RUN) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (last_cycle) begin
            state_d   = S_IDLE;
            pend_ok_d = 1'b0;
            if (pend_ok_q) begin
               hi_d = pend_q[63:32];
               lo_d = pend_q[31:0];
            end
         end
      end

      // Evaluated after the commit so a move issued on the completion edge wins.
      if (accept) begin
         case (MDOp)
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            MD_MULT, MD_MULTU: begin
               state_d   = S_RUN;
               cnt_d     = CNT_W'(MULT_CYCLES);
               pend_d    = calc_res;
               pend_ok_d = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
               state_d   = S_RUN;
               cnt_d     = CNT_W'(DIV_CYCLES);
               pend_d    = calc_res;
               pend_ok_d = !calc_div_zero;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pend_q    <= '0;
         pend_ok_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         pend_ok_q <= pend_ok_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign Busy = (state_q == S_RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule
